// File: rtl/craps_roll_ctrl.sv
// Roll-side controller for the craps datapath: debounced roll button, free-running
// dice, roll strobe to the outcome logic, and point / game-over bookkeeping.
module craps_roll_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EVAL_WAIT       = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       roll_btn,
   input  logic [1:0] op,
   output logic [2:0] die1,
   output logic [2:0] die2,
   output logic [3:0] sum,
   output logic [3:0] point,
   output logic       point_valid,
   output logic       roll_pulse,
   output logic       game_over,
   output logic [7:0] roll_count
);

   localparam int unsigned     DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ZERO   = {DB_W{1'b0}};
   localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1'b1);
   localparam logic [3:0]      EVAL_LAST = 4'(EVAL_WAIT);

   localparam logic [1:0] OP_REROLL = 2'b01;
   localparam logic [1:0] OP_WIN    = 2'b10;
   localparam logic [1:0] OP_LOSE   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EVAL = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            press_q, press_d;
   logic [2:0]      die_a_q, die_a_d;
   logic [2:0]      die_b_q, die_b_d;
   logic [2:0]      die1_q, die1_d;
   logic [2:0]      die2_q, die2_d;
   logic [3:0]      sum_q, sum_d;
   logic [3:0]      point_q, point_d;
   logic            point_valid_q, point_valid_d;
   logic            roll_pulse_q, roll_pulse_d;
   logic            game_over_q, game_over_d;
   logic [7:0]      roll_count_q, roll_count_d;
   logic [3:0]      wait_q, wait_d;

   // Dice engine: die_a runs 1..6 every cycle, die_b steps on each die_a wrap.
   always_comb begin
      die_a_d = die_a_q;
      die_b_d = die_b_q;
      if (die_a_q == 3'd6) begin
         die_a_d = 3'd1;
         if (die_b_q == 3'd6) begin
            die_b_d = 3'd1;
         end else begin
            die_b_d = die_b_q + 3'd1;
         end
      end else begin
         die_a_d = die_a_q + 3'd1;
         die_b_d = die_b_q;
      end
   end

   // Debounce: count consecutive cycles that disagree with the stable level;
   // a rising flip of the stable level raises press for exactly one cycle.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            db_cnt_d = DB_ZERO;
            press_d  = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
         end
      end else begin
         db_cnt_d = DB_ZERO;
      end
   end

   // Roll FSM: next state and all game-visible registers.
   always_comb begin
      state_d       = state_q;
      die1_d        = die1_q;
      die2_d        = die2_q;
      sum_d         = sum_q;
      point_d       = point_q;
      point_valid_d = point_valid_q;
      roll_pulse_d  = 1'b0;
      game_over_d   = game_over_q;
      roll_count_d  = roll_count_q;
      wait_d        = wait_q;

      case (state_q)
         ST_IDLE: begin
            if (press_q) begin
               die1_d       = die_a_q;
               die2_d       = die_b_q;
               sum_d        = {1'b0, die_a_q} + {1'b0, die_b_q};
               roll_pulse_d = 1'b1;
               wait_d       = 4'd0;
               state_d      = ST_EVAL;
               if (roll_count_q != 8'd255) begin
                  roll_count_d = roll_count_q + 8'd1;
               end else begin
                  roll_count_d = roll_count_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         // op is sampled once, EVAL_WAIT cycles after the roll_pulse cycle.
         ST_EVAL: begin
            if (wait_q == EVAL_LAST) begin
               case (op)
                  OP_REROLL: begin
                     if (!point_valid_q) begin
                        point_d       = sum_q;
                        point_valid_d = 1'b1;
                     end else begin
                        point_d       = point_q;
                        point_valid_d = point_valid_q;
                     end
                     state_d = ST_IDLE;
                  end
                  OP_WIN, OP_LOSE: begin
                     game_over_d = 1'b1;
                     state_d     = ST_DONE;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end

         // The press that leaves DONE restarts the game without rolling.
         ST_DONE: begin
            if (press_q) begin
               roll_pulse_d  = 1'b1;
               point_d       = 4'd0;
               point_valid_d = 1'b0;
               game_over_d   = 1'b0;
               roll_count_d  = 8'd0;
               state_d       = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         db_cnt_q      <= DB_ZERO;
         press_q       <= 1'b0;
         die_a_q       <= 3'd1;
         die_b_q       <= 3'd1;
         die1_q        <= 3'd1;
         die2_q        <= 3'd1;
         sum_q         <= 4'd0;
         point_q       <= 4'd0;
         point_valid_q <= 1'b0;
         roll_pulse_q  <= 1'b0;
         game_over_q   <= 1'b0;
         roll_count_q  <= 8'd0;
         wait_q        <= 4'd0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= roll_btn;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         db_cnt_q      <= db_cnt_d;
         press_q       <= press_d;
         die_a_q       <= die_a_d;
         die_b_q       <= die_b_d;
         die1_q        <= die1_d;
         die2_q        <= die2_d;
         sum_q         <= sum_d;
         point_q       <= point_d;
         point_valid_q <= point_valid_d;
         roll_pulse_q  <= roll_pulse_d;
         game_over_q   <= game_over_d;
         roll_count_q  <= roll_count_d;
         wait_q        <= wait_d;
      end
   end

   assign die1        = die1_q;
   assign die2        = die2_q;
   assign sum         = sum_q;
   assign point       = point_q;
   assign point_valid = point_valid_q;
   assign roll_pulse  = roll_pulse_q;
   assign game_over   = game_over_q;
   assign roll_count  = roll_count_q;

endmodule

// File: tb/tb_craps_roll_ctrl.sv
// Self-checking bench for craps_roll_ctrl: randomized rolls checked against a
// game-level model that derives dice from elapsed cycles since reset.
module tb_craps_roll_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, roll_btn;
   logic [1:0] op;
   logic [2:0] die1, die2;
   logic [3:0] sum, point;
   logic       point_valid, roll_pulse, game_over;
   logic [7:0] roll_count;

   logic       reset2, roll_btn2;
   logic [1:0] op2;
   logic [2:0] die1_2, die2_2;
   logic [3:0] sum2, point2;
   logic       point_valid2, roll_pulse2, game_over2;
   logic [7:0] roll_count2;

   craps_roll_ctrl dut (
      .clk(clk), .reset(reset), .roll_btn(roll_btn), .op(op),
      .die1(die1), .die2(die2), .sum(sum), .point(point),
      .point_valid(point_valid), .roll_pulse(roll_pulse),
      .game_over(game_over), .roll_count(roll_count)
   );

   craps_roll_ctrl #(.DEBOUNCE_CYCLES(4), .EVAL_WAIT(15)) dut2 (
      .clk(clk), .reset(reset2), .roll_btn(roll_btn2), .op(op2),
      .die1(die1_2), .die2(die2_2), .sum(sum2), .point(point2),
      .point_valid(point_valid2), .roll_pulse(roll_pulse2),
      .game_over(game_over2), .roll_count(roll_count2)
   );

   int vectors = 0;
   int miscompares = 0;

   // Clock edges since the last reset edge; dice phase follows directly from it.
   int n = 0;
   always @(posedge clk) begin
      if (!reset) n <= 0;
      else        n <= n + 1;
   end

   int pulse_cnt = 0, pulse_n = 0, pulse_cnt2 = 0;
   always @(negedge clk) begin
      if (roll_pulse === 1'b1) begin
         pulse_cnt <= pulse_cnt + 1;
         pulse_n   <= n;
      end
      if (roll_pulse2 === 1'b1) pulse_cnt2 <= pulse_cnt2 + 1;
   end

   // Game-level reference model.
   int m_die1, m_die2, m_sum, m_point, m_cnt;
   bit m_pv, m_over;

   task automatic model_reset();
      m_die1 = 1; m_die2 = 1; m_sum = 0; m_point = 0; m_cnt = 0;
      m_pv = 1'b0; m_over = 1'b0;
   endtask

   // m is the edge that produced roll_pulse; the dice latched there had
   // advanced m-1 times since reset.
   task automatic model_roll(input int m, input logic [1:0] opv);
      int idx;
      if (m_over) begin
         m_over = 1'b0; m_pv = 1'b0; m_point = 0; m_cnt = 0;
      end else begin
         idx    = (m - 1) % 36;
         m_die1 = 1 + idx % 6;
         m_die2 = 1 + idx / 6;
         m_sum  = m_die1 + m_die2;
         if (m_cnt < 255) m_cnt = m_cnt + 1;
         if (opv == 2'b01 && !m_pv) begin
            m_point = m_sum; m_pv = 1'b1;
         end else if (opv == 2'b10 || opv == 2'b11) begin
            m_over = 1'b1;
         end
      end
   endtask

   function automatic logic [23:0] exp_vec();
      return {3'(m_die1), 3'(m_die2), 4'(m_sum), 4'(m_point), m_pv, m_over, 8'(m_cnt)};
   endfunction

   task automatic tick(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   // One press/release of the roll button; optionally aligned so the latched
   // dice hit the 36-cycle phase idx (die1 = idx%6+1, die2 = idx/6+1).
   task automatic roll_once(input logic [1:0] opv, input bit tgt, input int idx, input string name);
      int c, p0, guard;
      logic [23:0] obs;
      if (tgt) begin
         guard = 0;
         while (((n + 18) % 36) != idx && guard < 40) begin
            tick(1);
            guard++;
         end
      end
      op = opv; p0 = pulse_cnt; c = n; roll_btn = 1'b1;
      guard = 0;
      while (pulse_cnt == p0 && guard < 40) begin
         tick(1);
         guard++;
      end
      vectors++;
      if (pulse_cnt == p0) begin
         $display("FAIL %s_pulse: no roll_pulse within 40 cycles, required one", name);
         miscompares++;
      end else begin
         if (pulse_n !== c + 19) begin
            $display("FAIL %s_latency: pulse at edge %0d, required %0d", name, pulse_n, c + 19);
            miscompares++;
         end
         model_roll(pulse_n, opv);
      end
      tick(1 + $urandom_range(0, 5));
      roll_btn = 1'b0;
      tick(22);
      vectors++;
      if (pulse_cnt !== p0 + 1) begin
         $display("FAIL %s_count: %0d pulses, required 1", name, pulse_cnt - p0);
         miscompares++;
      end
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== exp_vec()) begin
         $display("FAIL %s_state: got %h, required %h", name, obs, exp_vec());
         miscompares++;
      end
   endtask

   task automatic test_reset();
      logic [23:0] obs;
      reset = 1'b0; reset2 = 1'b0; roll_btn = 1'b0; roll_btn2 = 1'b0;
      op = 2'b00; op2 = 2'b00;
      tick(3);
      model_reset();
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== 24'h240000 || roll_pulse !== 1'b0) begin
         $display("FAIL reset_hold: got %h pulse %b, required 240000 pulse 0", obs, roll_pulse);
         miscompares++;
      end
      reset = 1'b1; reset2 = 1'b1;
      tick(1);
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== exp_vec() || roll_pulse !== 1'b0) begin
         $display("FAIL reset_release: got %h pulse %b, required %h pulse 0", obs, roll_pulse, exp_vec());
         miscompares++;
      end
   endtask

   task automatic test_debounce();
      int p0, c;
      logic [23:0] obs;
      op = 2'b10; p0 = pulse_cnt;
      roll_btn = 1'b1; tick(10); roll_btn = 1'b0; tick(40);
      vectors++;
      if (pulse_cnt !== p0) begin
         $display("FAIL glitch: %0d pulses, required 0", pulse_cnt - p0);
         miscompares++;
      end
      c = n; roll_btn = 1'b1; tick(40); roll_btn = 1'b0; tick(25);
      vectors++;
      if (pulse_cnt !== p0 + 1) begin
         $display("FAIL held_press: %0d pulses, required 1", pulse_cnt - p0);
         miscompares++;
      end else begin
         model_roll(pulse_n, 2'b10);
         vectors++;
         if (pulse_n !== c + 19) begin
            $display("FAIL held_latency: pulse at edge %0d, required %0d", pulse_n, c + 19);
            miscompares++;
         end
      end
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== exp_vec()) begin
         $display("FAIL held_state: got %h, required %h", obs, exp_vec());
         miscompares++;
      end
   endtask

   task automatic test_win_restart();
      roll_once(2'b00, 1'b0, 0, "done_clear");
      roll_once(2'b10, 1'b1, 20, "roll_3_4");
      vectors++;
      if (sum !== 4'd7 || game_over !== 1'b1 || point_valid !== 1'b0) begin
         $display("FAIL win_3_4: sum %0d over %b pv %b, required 7 1 0", sum, game_over, point_valid);
         miscompares++;
      end
      roll_once(2'b01, 1'b0, 0, "restart");
      vectors++;
      if (game_over !== 1'b0 || roll_count !== 8'd0 || sum !== 4'd7) begin
         $display("FAIL restart: over %b count %0d sum %0d, required 0 0 7", game_over, roll_count, sum);
         miscompares++;
      end
   endtask

   task automatic test_point();
      roll_once(2'b01, 1'b1, 19, "come_out_2_4");
      vectors++;
      if (point !== 4'd6 || point_valid !== 1'b1) begin
         $display("FAIL point_latch: point %0d pv %b, required 6 1", point, point_valid);
         miscompares++;
      end
      roll_once(2'b01, 1'b1, 34, "roll_5_6");
      vectors++;
      if (point !== 4'd6 || roll_count !== 8'd2 || sum !== 4'd11) begin
         $display("FAIL point_hold: point %0d count %0d sum %0d, required 6 2 11", point, roll_count, sum);
         miscompares++;
      end
   endtask

   task automatic test_reset_in_eval();
      int p0, guard;
      logic [23:0] obs;
      op = 2'b01; p0 = pulse_cnt; roll_btn = 1'b1;
      guard = 0;
      while (pulse_cnt == p0 && guard < 40) begin
         tick(1);
         guard++;
      end
      reset = 1'b0; roll_btn = 1'b0;
      tick(1);
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== 24'h240000 || roll_pulse !== 1'b0) begin
         $display("FAIL eval_reset: got %h pulse %b, required 240000 pulse 0", obs, roll_pulse);
         miscompares++;
      end
      tick(2);
      reset = 1'b1;
      model_reset();
      tick(5);
      obs = {die1, die2, sum, point, point_valid, game_over, roll_count};
      vectors++;
      if (obs !== exp_vec() || pulse_cnt !== p0 + 1) begin
         $display("FAIL eval_reset_after: got %h pulses %0d, required %h pulses 1", obs, pulse_cnt - p0, exp_vec());
         miscompares++;
      end
      roll_once(2'b01, 1'b0, 0, "idle_after_reset");
   endtask

   // Second instance has a long EVAL window so a second press can land inside it.
   task automatic test_eval_drop();
      int p0, guard;
      op2 = 2'b01; p0 = pulse_cnt2; roll_btn2 = 1'b1;
      guard = 0;
      while (pulse_cnt2 == p0 && guard < 40) begin
         tick(1);
         guard++;
      end
      roll_btn2 = 1'b0; tick(6);
      roll_btn2 = 1'b1; tick(30);
      roll_btn2 = 1'b0; tick(15);
      vectors++;
      if (pulse_cnt2 !== p0 + 1 || roll_count2 !== 8'd1) begin
         $display("FAIL eval_drop: pulses %0d count %0d, required 1 1", pulse_cnt2 - p0, roll_count2);
         miscompares++;
      end
      vectors++;
      if (point_valid2 !== 1'b1 || game_over2 !== 1'b0 || point2 < 4'd2 || point2 > 4'd12 ||
          sum2 < 4'd2 || sum2 > 4'd12 || die1_2 < 3'd1 || die1_2 > 3'd6 ||
          die2_2 < 3'd1 || die2_2 > 3'd6) begin
         $display("FAIL eval_drop_state: pv %b over %b point %0d sum %0d dice %0d %0d, required 1 0 in-range",
                  point_valid2, game_over2, point2, sum2, die1_2, die2_2);
         miscompares++;
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         tick($urandom_range(0, 7));
         roll_once(2'b01, 1'b0, 0, "sat_roll");
         vectors++;
         if (sum < 4'd2 || sum > 4'd12) begin
            $display("FAIL sum_range: sum %0d, required 2..12", sum);
            miscompares++;
         end
      end
      vectors++;
      if (roll_count !== 8'd255) begin
         $display("FAIL saturate: roll_count %0d, required 255", roll_count);
         miscompares++;
      end
   endtask

   task automatic test_random_games();
      for (int i = 0; i < 60; i++) begin
         tick($urandom_range(0, 11));
         roll_once(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 35)), "rand_roll");
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_win_restart();
      test_point();
      test_reset_in_eval();
      test_eval_drop();
      test_saturation();
      test_random_games();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
